// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin scheduler feeding a single 8N1 UART transmitter.
// One byte is granted per IDLE cycle; the frame then runs for 10 bit times.
module uart_tx_scheduler #(
    parameter int unsigned CLK_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt1,
    output logic       tx,
    output logic       busy,
    output logic       baud_en
);

    localparam int unsigned CntW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic            prio_q, prio_d;
    logic            tx_q, tx_d;
    logic            armed_q;
    logic            bit_done;
    logic            pick1;
    logic            grant;

    assign bit_done = (cnt_q == CntLast);
    // Requester 1 wins when it is alone or when the pointer favours it.
    assign pick1    = req1 & (~req0 | prio_q);
    // armed_q keeps grants off until the first clock edge after reset.
    assign grant    = armed_q & (req0 | req1) & (state_q == StIdle);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done && (idx_q == 3'd7)) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        gnt0    = grant & ~pick1;
        gnt1    = grant & pick1;
        busy    = (state_q != StIdle);
        baud_en = (state_q != StIdle);
    end

    assign tx = tx_q;

    // Datapath next values: bit timer, bit index, shift register, arbitration pointer
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        sh_d   = sh_q;
        prio_d = prio_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (grant) begin
                    sh_d   = pick1 ? data1 : data0;
                    prio_d = ~pick1;
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    sh_d  = {1'b0, sh_q[7:1]};
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                cnt_d = bit_done ? '0 : cnt_q + CntW'(1);
            end
        endcase
    end

    // tx is registered from the next state so the line level changes with the state.
    always_comb begin
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            prio_q  <= 1'b0;
            tx_q    <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            prio_q  <= prio_d;
            tx_q    <= tx_d;
            armed_q <= 1'b1;
        end
    end

    gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
    gnt_idle_a: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt0 || gnt1) |-> (state_q == StIdle));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized scoreboard bench for uart_tx_scheduler: a request-level arbitration
// model predicts grants, and a line monitor decodes each frame against the queue.
module tb_uart_tx_scheduler;

    localparam int unsigned Cpb = 4;
    localparam int FrameCyc = 10 * Cpb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       gnt0, gnt1, tx, busy, baud_en;

    uart_tx_scheduler #(
        .CLK_PER_BIT(Cpb)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .data0  (data0),
        .gnt0   (gnt0),
        .req1   (req1),
        .data1  (data1),
        .gnt1   (gnt1),
        .tx     (tx),
        .busy   (busy),
        .baud_en(baud_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_n = 0;
    int err_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state
    logic [7:0] pend0_q[$];
    logic [7:0] pend1_q[$];
    logic [7:0] frame_q[$];
    int         gcyc_q[$];
    bit         prio_m = 1'b0;
    int         free_at = 0;

    // Line receiver state
    bit         rx_on = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_byte = 8'h00;
    int         rx_gcyc = 0;
    bit         rx_bad_tx = 1'b0;
    bit         rx_bad_busy = 1'b0;

    // Monitor: arbitration model plus frame decoder, sampled on the falling edge.
    initial begin
        bit   who;
        bit   exp_any;
        bit   exp_who;
        int   b;
        logic lvl;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs", {gnt0, gnt1, tx, busy, baud_en}, 5'b00100);
                pend0_q.delete();
                pend1_q.delete();
                frame_q.delete();
                gcyc_q.delete();
                prio_m  = 1'b0;
                free_at = cyc + 1;
                rx_on   = 1'b0;
            end else begin
                check("baud_en_eq_busy", baud_en, busy);
                exp_any = (cyc >= free_at) && (req0 || req1);
                check("grant_present", gnt0 | gnt1, exp_any);
                if (gnt0 || gnt1) begin
                    exp_who = (req0 && req1) ? prio_m : req1;
                    who     = gnt1;
                    check("grant_onehot", gnt0 & gnt1, 0);
                    check("grant_winner", who, exp_who);
                    check("busy_at_grant", busy, 0);
                    if (who) begin
                        check("grant_has_pending", pend1_q.size() > 0, 1);
                        if (pend1_q.size() > 0) begin
                            frame_q.push_back(pend1_q.pop_front());
                            gcyc_q.push_back(cyc);
                        end
                    end else begin
                        check("grant_has_pending", pend0_q.size() > 0, 1);
                        if (pend0_q.size() > 0) begin
                            frame_q.push_back(pend0_q.pop_front());
                            gcyc_q.push_back(cyc);
                        end
                    end
                    prio_m  = !who;
                    free_at = cyc + FrameCyc + 1;
                end
                if (!rx_on) begin
                    if (tx === 1'b0) begin
                        rx_on       = 1'b1;
                        rx_t        = 0;
                        rx_bad_tx   = 1'b0;
                        rx_bad_busy = 1'b0;
                        check("frame_expected", frame_q.size() > 0, 1);
                        if (frame_q.size() > 0) begin
                            rx_byte = frame_q.pop_front();
                            rx_gcyc = gcyc_q.pop_front();
                            check("start_after_grant", cyc - rx_gcyc, 1);
                        end
                    end else begin
                        check("idle_busy_low", busy, 0);
                    end
                end
                if (rx_on) begin
                    if (rx_t < FrameCyc) begin
                        b = rx_t / Cpb;
                        if (b == 0) lvl = 1'b0;
                        else if (b == 9) lvl = 1'b1;
                        else lvl = rx_byte[b-1];
                        if (tx !== lvl) rx_bad_tx = 1'b1;
                        if (busy !== 1'b1) rx_bad_busy = 1'b1;
                        rx_t++;
                    end else begin
                        check("frame_tx_levels", rx_bad_tx, 0);
                        check("frame_busy_high", rx_bad_busy, 0);
                        check("frame_end_busy_low", busy, 0);
                        check("frame_end_tx_high", tx, 1);
                        rx_on = 1'b0;
                    end
                end
            end
        end
    end

    // Raise a request, hold it until granted, then drop it one edge later.
    task automatic drive(input int i, input logic [7:0] b);
        bit got = 1'b0;
        if (i == 0) begin
            req0 = 1'b1;
            data0 = b;
            pend0_q.push_back(b);
        end else begin
            req1 = 1'b1;
            data1 = b;
            pend1_q.push_back(b);
        end
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = (i == 0) ? gnt0 : gnt1;
        end
        check("grant_within_budget", got, 1);
        @(posedge clk);
        #1;
        if (i == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((frame_q.size() != 0 || rx_on) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", n < 300, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] r0, r1;
        int         mode, k;

        // Both requesters held from reset: 0x11, 0x22, 0x11, 0x22
        req0 = 1'b1;
        req1 = 1'b1;
        data0 = 8'h11;
        data1 = 8'h22;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        fork
            repeat (2) drive(0, 8'h11);
            repeat (2) drive(1, 8'h22);
        join
        wait_idle();

        // Single frame of 0xA5
        step(3);
        drive(0, 8'hA5);
        wait_idle();

        // Requester 1 alone, held continuously
        repeat (3) drive(1, 8'hFF);
        wait_idle();

        // Grant to 1 followed by both requesting: 0 must win
        drive(0, 8'h81);
        drive(1, 8'h5A);
        fork
            drive(0, 8'h3C);
            drive(1, 8'hC3);
        join
        wait_idle();

        // Short request pulse during a frame must be ignored
        drive(1, 8'h96);
        step(5);
        req0 = 1'b1;
        data0 = 8'h44;
        step(3);
        req0 = 1'b0;
        wait_idle();
        step(20);

        // Reset during data bit 3 of 0x00
        drive(0, 8'h00);
        step(15);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", tx, 1);
        check("async_reset_busy", busy, 0);
        check("async_reset_baud", baud_en, 0);
        check("async_reset_gnt", {gnt0, gnt1}, 0);
        req0 = 1'b1;
        data0 = 8'h77;
        repeat (3) @(negedge clk);
        req0 = 1'b0;
        #2;
        rst_n = 1'b1;
        step(50);

        // Request held across reset release: grant at the first allowed cycle
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req1 = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive(1, 8'hE7);
        wait_idle();

        // Randomized traffic
        for (int it = 0; it < 25; it++) begin
            mode = $urandom_range(0, 3);
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            k = $urandom_range(0, 50);
            case (mode)
                0: drive(0, r0);
                1: drive(1, r1);
                2: begin
                    fork
                        drive(0, r0);
                        begin
                            step(k);
                            drive(1, r1);
                        end
                    join
                end
                default: begin
                    drive(1, r1);
                    step($urandom_range(0, 15));
                    req0 = 1'b1;
                    data0 = r0;
                    step($urandom_range(1, 10));
                    req0 = 1'b0;
                    wait_idle();
                end
            endcase
            step($urandom_range(0, 3));
        end
        wait_idle();
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 1250: clk cycles per UART bit; legal range 2..2^31-1.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req0, input, 1 bit: requester 0 has a byte pending; held until gnt0.
REQ-005 The block SHALL have port data0, input, 8 bits: requester 0 byte; stable while req0 is high.
REQ-006 The block SHALL have port gnt0, output, 1 bit: one-cycle pulse; data0 is accepted in that cycle.
REQ-007 The block SHALL have ports req1, data1 and gnt1, identical to req0, data0 and gnt0 but for requester 1.
REQ-008 The block SHALL have port tx, output, 1 bit: serial line, 8N1, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is on tx.
REQ-010 The block SHALL have port baud_en, output, 1 bit: enable for an external baud generator; equals busy.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP, and SHALL reset to IDLE.
REQ-012 In IDLE with no request, the FSM SHALL stay in IDLE with tx=1 and busy=0.
REQ-013 In IDLE with at least one request, the block SHALL pulse exactly one gnt for 1 cycle, latch that requester's data into shift register sh[7:0], and move to START on the next edge.
REQ-014 Arbitration SHALL be round-robin using a 1-bit pointer prio: with both requests high, the requester with index prio SHALL be granted.
REQ-015 With only one request high, that requester SHALL be granted regardless of prio.
REQ-016 After every grant to requester i, prio SHALL become 1-i.
REQ-017 gnt0 and gnt1 SHALL never be high together, and SHALL be low in every state other than IDLE.
REQ-018 A bit timer cnt SHALL count 0..CLK_PER_BIT-1 and hold each tx level for exactly CLK_PER_BIT cycles.
REQ-019 cnt SHALL clear on entry to START and on every bit boundary; it SHALL be wide enough for CLK_PER_BIT-1 with no overflow.
REQ-020 In START, tx SHALL be 0 for one bit time, and the FSM SHALL then go to DATA.
REQ-021 In DATA, tx SHALL drive sh[0] for one bit time per bit, LSB first; sh SHALL shift right at each bit boundary and a 3-bit index SHALL count 0..7.
REQ-022 After bit index 7, the FSM SHALL go to STOP.
REQ-023 In STOP, tx SHALL be 1 for one bit time, and the FSM SHALL then go to IDLE.
REQ-024 A frame SHALL last exactly 10*CLK_PER_BIT cycles, with busy=1 throughout.
REQ-025 tx SHALL be registered: its first low cycle is the cycle after the grant.
REQ-026 Back-to-back frames SHALL be separated by exactly 1 IDLE cycle (the grant cycle), giving a frame period of 10*CLK_PER_BIT+1 cycles.
REQ-027 A request dropped before its grant SHALL cause no grant and no frame.
REQ-028 Requests arriving during a frame SHALL wait, and SHALL be arbitrated in the next IDLE cycle.
REQ-029 Input changes during a frame SHALL not affect the frame in progress.

Reset
REQ-030 While rst_n=0, the block SHALL hold state IDLE, tx=1, busy=0, baud_en=0, gnt0=gnt1=0, prio=0, cnt=0, bit index=0 and sh=0, taking effect immediately without waiting for clk.
REQ-031 Reset asserted mid-frame SHALL abort the frame with tx=1 at once; the aborted byte SHALL be lost and not re-granted.
REQ-032 After rst_n rises, the first grant SHALL occur no earlier than the first rising clk edge.

Verification (CLK_PER_BIT=4)
REQ-033 The bench SHALL cover: req0=1, data0=0xA5 -> gnt0 pulse; tx = 0 | 1,0,1,0,0,1,0,1 | 1, each level 4 cycles; busy high 40 cycles.
REQ-034 The bench SHALL cover: req0 and req1 both held from reset, data0=0x11, data1=0x22 -> bytes sent in order 0x11, 0x22, 0x11, 0x22; grants 41 cycles apart.
REQ-035 The bench SHALL cover: only req1 held continuously, data1=0xFF -> gnt1 every 41 cycles; tx low only during each start bit.
REQ-036 The bench SHALL cover: rst_n=0 during DATA bit 3 of 0x00 -> tx=1 and busy=0 before the next clk edge; no gnt until rst_n=1.
REQ-037 The bench SHALL cover: req0 pulsed high then dropped during a frame -> no gnt0 and no extra frame after the current one.
REQ-038 The bench SHALL cover: a grant to requester 1 followed by both requesting -> requester 0 granted next.
